// File: rtl/rf_dump_loader.sv
// rf_dump_loader: sequential dump/load engine for the register file.
// Streams all registers out, or fills registers 1..N-1 from a stream.
module rf_dump_loader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_dump,
    input  logic              start_load,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_index,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DUMP = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    // Set once the last register is captured so idx cannot wrap to 0.
    logic              capd_q, capd_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] dd_q, dd_d;
    logic [ADDR_W-1:0] di_q, di_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic dump_xfer;
    logic load_xfer;
    logic can_cap;

    assign dump_xfer = dv_q & dump_ready;
    assign load_xfer = load_valid & (state_q == S_LOAD);
    assign can_cap   = (!dv_q || dump_xfer) && !capd_q;

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign load_ready    = (state_q == S_LOAD);
    assign rf_read_addr  = (state_q == S_DUMP) ? idx_q : '0;
    assign rf_write_en   = wen_q;
    assign rf_write_addr = waddr_q;
    assign rf_write_data = wdata_q;
    assign dump_valid    = dv_q;
    assign dump_data     = dd_q;
    assign dump_index    = di_q;

    // Next-state logic for the sequencer, output register and write port.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capd_d  = capd_q;
        dv_d    = dv_q;
        dd_d    = dd_q;
        di_d    = di_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_dump) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                    capd_d  = 1'b0;
                end else if (start_load) begin
                    state_d = S_LOAD;
                    idx_d   = ONE;
                end
            end
            S_DUMP: begin
                if (dump_xfer) begin
                    dv_d = 1'b0;
                    if (di_q == LAST) begin
                        state_d = S_FIN;
                    end
                end
                if (can_cap) begin
                    dv_d  = 1'b1;
                    dd_d  = rf_read_data;
                    di_d  = idx_q;
                    idx_d = idx_q + ONE;
                    if (idx_q == LAST) begin
                        capd_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (load_xfer) begin
                    wen_d   = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = load_data;
                    idx_d   = idx_q + ONE;
                    if (idx_q == LAST) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset also drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            capd_q  <= 1'b0;
            dv_q    <= 1'b0;
            dd_q    <= '0;
            di_q    <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            capd_q  <= capd_d;
            dv_q    <= dv_d;
            dd_q    <= dd_d;
            di_q    <= di_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/rf_dump_loader.md
# rf_dump_loader

Sequential initiator for the 32×32 register file's read and write ports. It streams the whole register file out over a valid/ready interface (dump) or fills registers 1–31 from an incoming valid/ready stream (load). It sits beside the register file and is used for debug/test access, context save/restore and boot-time initialisation. While `busy` is high, the core's register-port mux selects this block.

## Interface
Parameters:
- `NUM_REGS`, default 32: number of registers.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `start_dump` in 1: request a full dump; sampled only in IDLE.
- `start_load` in 1: request a load of registers 1..31; sampled only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE; the core uses it as the port-mux select.
- `done` out 1: one-cycle pulse when an operation completes.
- `rf_read_addr` out ADDR_W: register-file read address.
- `rf_read_data` in DATA_W: combinational read data; address 0 returns 0.
- `rf_write_en` out 1: register-file write strobe.
- `rf_write_addr` out ADDR_W: write address.
- `rf_write_data` out DATA_W: write data.
- `dump_valid` out 1, `dump_ready` in 1: dump stream handshake.
- `dump_data` out DATA_W: dumped register value.
- `dump_index` out ADDR_W: register number of `dump_data`.
- `load_valid` in 1, `load_ready` out 1: load stream handshake.
- `load_data` in DATA_W: value to write.

## Operation
- **States:** IDLE, DUMP, LOAD, FIN.
- **Index counter:** `idx` is ADDR_W bits wide.
- **Transfer rules:**
  - Dump handshake: `dump_valid & dump_ready` at an edge.
  - Load handshake: `load_valid & load_ready` at an edge.
- **IDLE:**
  - `start_dump` → DUMP, with `idx`=0.
  - Else `start_load` → LOAD, with `idx`=1.
  - If both are high, dump wins and `start_load` is dropped.
  - Starts arriving in other states are ignored (not queued).
- **DUMP:**
  - `rf_read_addr`=`idx`.
  - A one-entry output register holds `dump_data`/`dump_index`.
  - On an edge where the output register is empty, or is being consumed by a dump transfer, and `idx` has not passed 31:
    - capture `rf_read_data` and `idx` into the output register;
    - set `dump_valid`;
    - increment `idx`.
  - Once `idx` 31 is captured, no further captures occur (no wrap to 0).
  - The transfer of index 31 moves the state to FIN.
  - `dump_data` and `dump_index` stay stable while `dump_valid & !dump_ready`.
- **LOAD:**
  - `load_ready`=1.
  - On each load transfer, register `rf_write_en`=1, `rf_write_addr`=`idx` and `rf_write_data`=`load_data`, then increment `idx`.
  - The transfer at `idx`=31 moves the state to FIN.
  - Register 0 is never written.
  - With no load transfer, `rf_write_en` is registered to 0.
- **FIN:** one cycle; `rf_write_en` registered to 0. Next state is IDLE with `done`=1 for that cycle.
- **`rf_write_en` rule:** `rf_write_en` is never high outside the cycle following a load transfer, and is never high in DUMP.
- **Reset values** (asynchronous, on `reset`=0; applies mid-operation too):
  - state=IDLE, `idx`=0, `busy`=0, `done`=0;
  - `dump_valid`=0, `dump_data`=0, `dump_index`=0;
  - `load_ready`=0, `rf_read_addr`=0;
  - `rf_write_en`=0, `rf_write_addr`=0, `rf_write_data`=0.
- **Reset mid-operation:** a pending registered write is discarded. Registers already written keep their values.

## Timing
- **Start:** start sampled at edge E0 → `busy`=1 after E0.
- **Dump latency:**
  - The first capture happens at E1, so `dump_valid` is high after E1.
  - With `dump_ready` tied high: one word per cycle, indices 0..31 valid after E1..E32.
  - The last transfer is at E33. FIN occupies the cycle after E33, during which `done`=1 and `busy`=1.
  - IDLE is entered at E34, after which `busy`=0.
- **Load latency:**
  - `load_ready`=1 after E0.
  - A transfer at edge Ek gives `rf_write_en`=1 during the cycle after Ek, and the register file commits at E(k+1).
  - After the final (31st) transfer, `load_ready` drops to 0 at that same edge.
  - The FIN cycle follows, carrying `done`=1 and the last write.
- **Handshake rules:**
  - `dump_valid` does not depend combinationally on `dump_ready`.
  - `load_ready` is purely state-driven.
- **Back-to-back operations:** a start in the cycle after `done` is accepted.

## Test plan
- **Reset:** assert `reset`=0 mid-DUMP → all outputs read their reset values immediately (async); after release, `busy`=0 and no `done` pulse.
- **Full dump:** preload rN=0x1000_0000+N, `dump_ready`=1, pulse `start_dump` → 32 transfers, index 0 carries 0x0000_0000, index 31 carries 0x1000_001F; `done` pulses once, 34 cycles after start.
- **Backpressure:** toggle `dump_ready` 1-0-0-1 → data and index held while stalled, no index skipped or duplicated, order 0..31.
- **Load:** stream 0xA5A5_0000+i for i=1..31 with `load_valid` gaps → exactly 31 `rf_write_en` pulses at addresses 1..31; a following dump returns those values with r0=0.
- **Simultaneous starts:** `start_dump` and `start_load` high together in IDLE → DUMP runs and no writes occur; a `start_load` pulse during DUMP is ignored.
- **Reset mid-load:** reset after the 10th transfer → r1..r9 are written, the 10th pending write is dropped, `load_ready`=0, and r11..r31 are unchanged.
